adsr_envelope_gen: RTL and testbench

- Attack/decay/sustain/release envelope generator that produces the low-frequency modulating word for the amplitude modulator.
- Runs from a per-sample tick and is gated by a note gate.
- Emits one non-negative signed envelope sample per tick over a valid/ready handshake.
- Sits directly upstream of the amplitude modulator's modulator input.

---
 rtl/adsr_envelope_gen.sv | 203 ++++++++++++++++++++
 tb/tb_adsr_envelope_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator.
// Produces one non-negative envelope sample per sample tick, gated by a note
// gate, and presents it over a valid/ready handshake to the amplitude
// modulator. The envelope level is an unsigned (DATA_WIDTH-1)-bit value.
// It is zero-extended onto the signed output word.
module adsr_envelope_gen #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         tick_i,
    input  logic                         gate_i,
    input  logic        [DATA_WIDTH-2:0] attack_rate_i,
    input  logic        [DATA_WIDTH-2:0] decay_rate_i,
    input  logic        [DATA_WIDTH-2:0] sustain_level_i,
    input  logic        [DATA_WIDTH-2:0] release_rate_i,
    output logic signed [DATA_WIDTH-1:0] envelope_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic        [2:0]            state_o,
    output logic                         overrun_o
);

    // Width of the unsigned envelope level (sign bit excluded).
    localparam int LW = DATA_WIDTH - 1;

    // Full-scale level, 2^(DATA_WIDTH-1)-1.
    localparam logic [LW-1:0] MAX_LEVEL = '1;

    // The state encodings are visible on state_o, so they are fixed.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t        state_q,   state_d;
    logic [LW-1:0] level_q,   level_d;
    logic          gate_q,    gate_d;
    logic          valid_q,   valid_d;
    logic          overrun_q, overrun_d;

    // State after this cycle's gate event. The level rule is applied to it.
    state_t        gate_state;
    logic          gate_rise;

    // Arithmetic with one guard/borrow bit so no result can wrap.
    logic [LW:0]   attack_sum;
    logic [LW:0]   decay_diff;
    logic [LW:0]   release_diff;
    logic          decay_borrow;
    logic          release_borrow;

    // ------------------------------------------------------------------
    // State register: FSM state, level, registered gate and output flags
    // ------------------------------------------------------------------
    // Reset clears gate_q, so a gate that is already high when reset
    // releases is seen as a note-on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            level_q   <= '0;
            gate_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments only. Every
            // flop then samples pre-edge values, whatever the statement order.
            state_q   <= state_d;
            level_q   <= level_d;
            gate_q    <= gate_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Gate handling: resolve note-on / note-off before any level update
    // ------------------------------------------------------------------
    // A rising edge retriggers ATTACK from any state. A low gate sends an
    // active note to RELEASE. IDLE and RELEASE ignore a low gate.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first. A missed branch then cannot infer a latch.
        gate_d     = gate_i;
        gate_rise  = gate_i & ~gate_q;
        gate_state = state_q;
        if (gate_rise) begin
            gate_state = ST_ATTACK;
        end else if (!gate_i) begin
            if (state_q == ST_ATTACK || state_q == ST_DECAY ||
                state_q == ST_SUSTAIN) begin
                gate_state = ST_RELEASE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating level arithmetic shared by the next-state logic
    // ------------------------------------------------------------------
    // The sum and differences carry one extra MSB. It is the overflow bit
    // in ATTACK and the borrow bit in DECAY and RELEASE.
    always_comb begin
        attack_sum     = {1'b0, level_q} + {1'b0, attack_rate_i};
        decay_diff     = {1'b0, level_q} - {1'b0, decay_rate_i};
        release_diff   = {1'b0, level_q} - {1'b0, release_rate_i};
        decay_borrow   = decay_diff[LW];
        release_borrow = release_diff[LW];
    end

    // ------------------------------------------------------------------
    // Next-state logic: level update and phase transitions on tick cycles
    // ------------------------------------------------------------------
    // Without a tick only the gate transition applies and the level holds.
    // With a tick, the rule of the post-gate state sets the new level. It
    // may also advance to the next phase in the same cycle.
    always_comb begin
        state_d = gate_state;
        level_d = level_q;
        if (tick_i) begin
            unique case (gate_state)
                ST_IDLE: begin
                    level_d = '0;
                end
                ST_ATTACK: begin
                    // A zero rate means an instantaneous attack.
                    if (attack_rate_i == '0 || attack_sum >= {1'b0, MAX_LEVEL}) begin
                        level_d = MAX_LEVEL;
                        state_d = ST_DECAY;
                    end else begin
                        level_d = attack_sum[LW-1:0];
                    end
                end
                ST_DECAY: begin
                    // Floor at the sustain level. A zero rate jumps straight
                    // to it.
                    if (decay_rate_i == '0 || decay_borrow ||
                        decay_diff[LW-1:0] <= sustain_level_i) begin
                        level_d = sustain_level_i;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = decay_diff[LW-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    // Follows live sustain-level changes in either direction.
                    level_d = sustain_level_i;
                end
                ST_RELEASE: begin
                    // Floor at zero. Reaching zero ends the note.
                    if (release_rate_i == '0 || release_borrow ||
                        release_diff[LW-1:0] == '0) begin
                        level_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = release_diff[LW-1:0];
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake: sample-valid tracking and overrun detection
    // ------------------------------------------------------------------
    // A tick always publishes a fresh sample. Without a tick, acceptance
    // retires the sample. A tick that lands on a held, unaccepted sample
    // overwrites it and flags an overrun. A tick in the acceptance cycle is
    // not an overrun.
    always_comb begin
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (tick_i) begin
            valid_d   = 1'b1;
            overrun_d = valid_q & ~ready_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: drive ports from the registered state
    // ------------------------------------------------------------------
    // The level changes only on a tick, and a tick also republishes the
    // sample. So the zero-extended level is the held output word and stays
    // stable until the next tick.
    always_comb begin
        envelope_o = {1'b0, level_q};
        valid_o    = valid_q;
        state_o    = state_q;
        overrun_o  = overrun_q;
    end

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Self-checking bench for adsr_envelope_gen.
// A table of tick vectors covers reset-idle ticks, the full attack/decay/
// sustain run and release. Hand-written sequences cover retrigger, the
// handshake/overrun corners, zero rates and asynchronous reset.
module tb_adsr_envelope_gen;

    localparam int DW = 16;

    logic                 clk_i;
    logic                 rst_ni;
    logic                 tick_i;
    logic                 gate_i;
    logic        [DW-2:0] attack_rate_i;
    logic        [DW-2:0] decay_rate_i;
    logic        [DW-2:0] sustain_level_i;
    logic        [DW-2:0] release_rate_i;
    logic signed [DW-1:0] envelope_o;
    logic                 valid_o;
    logic                 ready_i;
    logic        [2:0]    state_o;
    logic                 overrun_o;

    int n_checks;
    int n_pass;

    adsr_envelope_gen #(.DATA_WIDTH(DW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .tick_i          (tick_i),
        .gate_i          (gate_i),
        .attack_rate_i   (attack_rate_i),
        .decay_rate_i    (decay_rate_i),
        .sustain_level_i (sustain_level_i),
        .release_rate_i  (release_rate_i),
        .envelope_o      (envelope_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .state_o         (state_o),
        .overrun_o       (overrun_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One vector = n_idle tick-free cycles, then one tick cycle, then a
    // check of the sample seen in the cycle after the tick.
    typedef struct {
        int          n_idle;
        logic        gate;
        logic        ready;
        logic [14:0] atk;
        logic [14:0] dec;
        logic [14:0] sus;
        logic [14:0] rel;
        logic [15:0] env;
        logic        valid;
        logic [2:0]  state;
        logic        ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int n_idle, input logic gate,
                                input logic [14:0] atk, input logic [14:0] dec,
                                input logic [14:0] sus, input logic [14:0] rel,
                                input logic [15:0] env, input logic [2:0] state);
        vec_t v;
        v.n_idle = n_idle;
        v.gate   = gate;
        v.ready  = 1'b1;
        v.atk    = atk;
        v.dec    = dec;
        v.sus    = sus;
        v.rel    = rel;
        v.env    = env;
        v.valid  = 1'b1;
        v.state  = state;
        v.ovr    = 1'b0;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive tick for one rising edge. Return on the next falling edge, where
    // the outputs for the cycle after that edge are stable.
    task automatic cyc(input logic t);
        tick_i = t;
        @(negedge clk_i);
        tick_i = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [15:0] env,
                             input logic valid, input logic [2:0] state,
                             input logic ovr);
        check({tag, ".env"},   32'(envelope_o), 32'(env));
        check({tag, ".valid"}, 32'(valid_o),    32'(valid));
        check({tag, ".state"}, 32'(state_o),    32'(state));
        check({tag, ".ovr"},   32'(overrun_o),  32'(ovr));
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst_ni          = 1'b0;
        tick_i          = 1'b0;
        gate_i          = 1'b0;
        ready_i         = 1'b1;
        attack_rate_i   = '0;
        decay_rate_i    = '0;
        sustain_level_i = '0;
        release_rate_i  = '0;

        // Plan 1: idle ticks give zero samples.
        for (int i = 0; i < 3; i++) add(2, 1'b0, 0, 0, 0, 0, 0, 3'd0);
        // Plan 2: attack 10000, decay 5000, sustain 12000, one tick per 4 cycles.
        add(3, 1'b1, 10000, 5000, 12000, 5000, 10000, 3'd1);
        add(3, 1'b1, 10000, 5000, 12000, 5000, 20000, 3'd1);
        add(3, 1'b1, 10000, 5000, 12000, 5000, 30000, 3'd1);
        add(3, 1'b1, 10000, 5000, 12000, 5000, 32767, 3'd2);
        add(3, 1'b1, 10000, 5000, 12000, 5000, 27767, 3'd2);
        add(3, 1'b1, 10000, 5000, 12000, 5000, 22767, 3'd2);
        add(3, 1'b1, 10000, 5000, 12000, 5000, 17767, 3'd2);
        add(3, 1'b1, 10000, 5000, 12000, 5000, 12767, 3'd2);
        add(3, 1'b1, 10000, 5000, 12000, 5000, 12000, 3'd3);
        add(3, 1'b1, 10000, 5000, 12000, 5000, 12000, 3'd3);
        // Plan 3: note off, release 5000 down to zero, then idle.
        add(3, 1'b0, 10000, 5000, 12000, 5000, 7000, 3'd4);
        add(3, 1'b0, 10000, 5000, 12000, 5000, 2000, 3'd4);
        add(3, 1'b0, 10000, 5000, 12000, 5000, 0,    3'd0);
        add(3, 1'b0, 10000, 5000, 12000, 5000, 0,    3'd0);

        #12;
        check_out("reset", 0, 1'b0, 3'd0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        foreach (vecs[k]) begin
            gate_i          = vecs[k].gate;
            ready_i         = vecs[k].ready;
            attack_rate_i   = vecs[k].atk;
            decay_rate_i    = vecs[k].dec;
            sustain_level_i = vecs[k].sus;
            release_rate_i  = vecs[k].rel;
            for (int i = 0; i < vecs[k].n_idle; i++) cyc(1'b0);
            cyc(1'b1);
            check_out($sformatf("vec%0d", k), vecs[k].env, vecs[k].valid,
                      vecs[k].state, vecs[k].ovr);
        end

        // Plan 4: retrigger from RELEASE keeps the current level.
        gate_i = 1'b1; attack_rate_i = 0; decay_rate_i = 0;
        sustain_level_i = 12000; release_rate_i = 5000;
        cyc(1'b1); check_out("rt_max", 32767, 1'b1, 3'd2, 1'b0);
        cyc(1'b1); check_out("rt_sus", 12000, 1'b1, 3'd3, 1'b0);
        gate_i = 1'b0;
        cyc(1'b1); check_out("rt_rel", 7000, 1'b1, 3'd4, 1'b0);
        gate_i = 1'b1; attack_rate_i = 10000;
        cyc(1'b0); check_out("rt_edge", 7000, 1'b0, 3'd1, 1'b0);
        cyc(1'b1); check_out("rt_atk", 17000, 1'b1, 3'd1, 1'b0);

        // Plan 5: held sample, overrun, then a tick in the acceptance cycle.
        attack_rate_i = 1000;
        cyc(1'b0); check("hs_drain.valid", 32'(valid_o), 32'd0);
        ready_i = 1'b0;
        cyc(1'b1); check_out("hs_s1", 18000, 1'b1, 3'd1, 1'b0);
        cyc(1'b0); check_out("hs_hold1", 18000, 1'b1, 3'd1, 1'b0);
        cyc(1'b0); check_out("hs_hold2", 18000, 1'b1, 3'd1, 1'b0);
        cyc(1'b1); check_out("hs_ovr", 19000, 1'b1, 3'd1, 1'b1);
        cyc(1'b0); check_out("hs_ovr_end", 19000, 1'b1, 3'd1, 1'b0);
        ready_i = 1'b1;
        cyc(1'b1); check_out("hs_acc_tick", 20000, 1'b1, 3'd1, 1'b0);
        cyc(1'b0); check_out("hs_accept", 20000, 1'b0, 3'd1, 1'b0);

        // Plan 6: zero attack/decay rates, then asynchronous reset.
        gate_i = 1'b0;
        cyc(1'b0); check("z_rel.state", 32'(state_o), 32'd4);
        gate_i = 1'b1; attack_rate_i = 0; decay_rate_i = 0; sustain_level_i = 9000;
        cyc(1'b1); check_out("z_atk", 32767, 1'b1, 3'd2, 1'b0);
        cyc(1'b1); check_out("z_dec", 9000, 1'b1, 3'd3, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_out("async_rst", 0, 1'b0, 3'd0, 1'b0);
        @(negedge clk_i);
        check_out("rst_hold", 0, 1'b0, 3'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
